// File: rtl/bs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bs_pkg
// Description : Shared constants and state encoding for the barrel-shifter
//               arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package bs_pkg;

    localparam int BS_DATA_W  = 32;
    localparam int BS_AMT_W   = 5;
    localparam int BS_OPSEL_W = 3;

    // Shifter operation encodings; unlisted codes pass data through.
    localparam logic [BS_OPSEL_W-1:0] BS_OP_SLL = 3'd0;
    localparam logic [BS_OPSEL_W-1:0] BS_OP_SRL = 3'd1;
    localparam logic [BS_OPSEL_W-1:0] BS_OP_SRA = 3'd2;
    localparam logic [BS_OPSEL_W-1:0] BS_OP_ROL = 3'd3;
    localparam logic [BS_OPSEL_W-1:0] BS_OP_ROR = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } bs_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shifter
// Description : Combinational 32-bit shifter: logical/arithmetic shifts and
//               rotates selected by bs_opsel; other codes pass data through.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shifter
    import bs_pkg::*;
(
    input  logic [BS_DATA_W-1:0]  data_in,
    input  logic [BS_AMT_W-1:0]   shift_amount,
    input  logic [BS_OPSEL_W-1:0] bs_opsel,
    output logic [BS_DATA_W-1:0]  result
);

    // Complementary shift distance for rotates; 32 when amount is 0, which
    // shifts everything out and leaves the rotate equal to the input.
    logic [BS_AMT_W:0] w_inv_amt;
    assign w_inv_amt = 6'd32 - {1'b0, shift_amount};

    // Select the shift flavour.
    always_comb begin
        result = data_in;
        case (bs_opsel)
            BS_OP_SLL: result = data_in << shift_amount;
            BS_OP_SRL: result = data_in >> shift_amount;
            BS_OP_SRA: result = $unsigned($signed(data_in) >>> shift_amount);
            BS_OP_ROL: result = (data_in << shift_amount) | (data_in >> w_inv_amt);
            BS_OP_ROR: result = (data_in >> shift_amount) | (data_in << w_inv_amt);
            default:   result = data_in;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bs_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant
// Description : Combinational round-robin select: first asserted request at
//               or above ptr (modulo N), returned one-hot and encoded.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int   w_cand;
    logic w_found;

    // Walk the requests starting at ptr and take the first one found.
    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < N; i++) begin
            w_cand = int'(ptr) + i;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!w_found && req[w_cand]) begin
                w_found       = 1'b1;
                grant[w_cand] = 1'b1;
                idx           = IW'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bs_arbiter
// Description : Round-robin arbiter/sequencer sharing one barrel_shifter
//               among NUM_REQ requesters; tagged valid/ready responses.
// Revision    : 1.0 - initial release
// ============================================================================
module bs_arbiter
    import bs_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [BS_OPSEL_W*NUM_REQ-1:0] req_opsel,
    input  logic [BS_AMT_W*NUM_REQ-1:0]   req_amt,
    input  logic [BS_DATA_W*NUM_REQ-1:0]  req_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [BS_DATA_W-1:0]          rsp_data,
    output logic [IDW-1:0]                rsp_id,
    output logic                          busy
);

    bs_arb_state_t         r_state, w_state_nxt;
    logic [IDW-1:0]        r_rr_ptr, r_win_id, w_ptr_nxt;
    logic [BS_OPSEL_W-1:0] r_opsel;
    logic [BS_AMT_W-1:0]   r_amt;
    logic [BS_DATA_W-1:0]  r_data, r_rsp_data, w_result;
    logic [IDW-1:0]        r_rsp_id;
    logic                  r_rsp_valid;
    logic [NUM_REQ-1:0]    w_grant;
    logic [IDW-1:0]        w_grant_idx;
    logic                  w_accept, w_capture, w_release;

    rr_grant #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_grant (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_grant_idx)
    );

    barrel_shifter u_shifter (
        .data_in      (r_data),
        .shift_amount (r_amt),
        .bs_opsel     (r_opsel),
        .result       (w_result)
    );

    // Next state and per-state strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The requester just served drops to lowest priority; wrap at NUM_REQ-1.
    assign w_ptr_nxt = (r_win_id == IDW'(NUM_REQ - 1)) ? '0 : r_win_id + 1'b1;

    // Operand capture, result capture and pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opsel     <= '0;
            r_amt       <= '0;
            r_data      <= '0;
            r_win_id    <= '0;
            r_rr_ptr    <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opsel  <= req_opsel[int'(w_grant_idx)*BS_OPSEL_W +: BS_OPSEL_W];
                r_amt    <= req_amt[int'(w_grant_idx)*BS_AMT_W +: BS_AMT_W];
                r_data   <= req_data[int'(w_grant_idx)*BS_DATA_W +: BS_DATA_W];
                r_win_id <= w_grant_idx;
            end
            if (w_capture) begin
                r_rsp_data  <= w_result;
                r_rsp_id    <= r_win_id;
                r_rsp_valid <= 1'b1;
            end
            if (w_release) begin
                r_rsp_valid <= 1'b0;
                r_rr_ptr    <= w_ptr_nxt;
            end
        end
    end

    // Grant is only offered while idle and never while reset is asserted.
    assign req_ready = (r_state == IDLE && !rst) ? w_grant : '0;
    assign busy      = (r_state != IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule
`default_nettype wire
